// File: rtl/equiv_mismatch_monitor.sv
// Equivalence-harness output monitor: warm-up skip, mismatch flag/count, and a FWFT record FIFO.
// Optional macro EQV_STOP_ON_ERR_EN: return to IDLE after the first recorded mismatch.
module equiv_mismatch_monitor #(
    parameter int unsigned WIDTH  = 91,
    parameter int unsigned WARMUP = 4,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned ERR_W  = 16,
    parameter int unsigned DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] y_1,
    input  logic [WIDTH-1:0] y_2,
    output logic             busy,
    output logic             checking,
    output logic             fail,
    output logic [ERR_W-1:0] err_cnt,
    output logic             overflow,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [CNT_W-1:0] rec_cycle,
    output logic [WIDTH-1:0] rec_diff
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] WARM_LAST = (WARMUP > 0) ? CNT_W'(WARMUP - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WARMUP,
        S_CHECK
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cyc_cnt;

    logic [CNT_W-1:0] mem_cycle [DEPTH];
    logic [WIDTH-1:0] mem_diff  [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_inc;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;

    logic             mismatch;
    logic             hit;
    logic             pop;
    logic             full;
    logic             push;
    logic             drop;
    logic [WIDTH-1:0] diff;
    logic [CNT_W-1:0] head_cycle_nxt;
    logic [WIDTH-1:0] head_diff_nxt;

    always_comb begin
        diff       = y_1 ^ y_2;
        mismatch   = (y_1 != y_2);
        hit        = (state == S_CHECK) && !start && mismatch;
        pop        = rec_valid && rec_ready && !start;
        full       = (count == FULL_CNT);
        push       = hit && (!full || pop);
        drop       = hit && full && !pop;
        rd_ptr_inc = rd_ptr + AW'(1);

        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + (AW+1)'(1);
            2'b01:   count_nxt = count - (AW+1)'(1);
            default: count_nxt = count;
        endcase

        // The head register tracks the entry that will sit at rd_ptr after this edge;
        // a push into an empty (or just-emptied) FIFO bypasses the memory.
        head_cycle_nxt = rec_cycle;
        head_diff_nxt  = rec_diff;
        if (push && ((count == '0) || ((count == (AW+1)'(1)) && pop))) begin
            head_cycle_nxt = cyc_cnt;
            head_diff_nxt  = diff;
        end else if (pop && (count > (AW+1)'(1))) begin
            head_cycle_nxt = mem_cycle[rd_ptr_inc];
            head_diff_nxt  = mem_diff[rd_ptr_inc];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cyc_cnt  <= '0;
            busy     <= 1'b0;
            checking <= 1'b0;
            fail     <= 1'b0;
            err_cnt  <= '0;
            overflow <= 1'b0;
        end else if (start) begin
            cyc_cnt  <= '0;
            fail     <= 1'b0;
            err_cnt  <= '0;
            overflow <= 1'b0;
            busy     <= 1'b1;
            if (WARMUP == 0) begin
                state    <= S_CHECK;
                checking <= 1'b1;
            end else begin
                state    <= S_WARMUP;
                checking <= 1'b0;
            end
        end else begin
            case (state)
                S_WARMUP: begin
                    cyc_cnt <= cyc_cnt + CNT_W'(1);
                    if (cyc_cnt == WARM_LAST) begin
                        state    <= S_CHECK;
                        checking <= 1'b1;
                    end
                end
                S_CHECK: begin
                    cyc_cnt <= cyc_cnt + CNT_W'(1);
                    if (mismatch) begin
                        fail <= 1'b1;
                        if (err_cnt != '1) begin
                            err_cnt <= err_cnt + ERR_W'(1);
                        end
                        if (drop) begin
                            overflow <= 1'b1;
                        end
`ifdef EQV_STOP_ON_ERR_EN
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        checking <= 1'b0;
`endif
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    busy     <= 1'b0;
                    checking <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rec_valid <= 1'b0;
            rec_cycle <= '0;
            rec_diff  <= '0;
        end else if (start) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rec_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            count     <= count_nxt;
            rec_valid <= (count_nxt != '0);
            rec_cycle <= head_cycle_nxt;
            rec_diff  <= head_diff_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_cycle[wr_ptr] <= cyc_cnt;
            mem_diff[wr_ptr]  <= diff;
        end
    end

endmodule

// File: doc/equiv_mismatch_monitor.md
Name: equiv_mismatch_monitor

Overview:
Downstream consumer of the equivalence harness outputs y_1/y_2. Samples both design outputs every clock and skips a programmable warm-up window in which the registers are still unconstrained. It then flags any divergence, counts mismatches and buffers per-mismatch records (cycle stamp plus XOR difference) in a small FIFO that a logger drains via valid/ready. It gives the harness a simulatable, reportable failure path alongside the formal assert.

Parameters:
WIDTH, 91, width of y_1/y_2 (matches the 7'h5a:0 harness outputs)
WARMUP, 4, number of cycles after start before comparison begins (0 allowed)
CNT_W, 32, width of cycle stamp counter
ERR_W, 16, width of mismatch counter
DEPTH, 4, record FIFO depth; power of two, >= 2

Ports:
clk  input  1  rising-edge clock, shared with top_1/top_2
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse: (re)arm the monitor
y_1  input  WIDTH  output of design 1
y_2  input  WIDTH  output of design 2
busy  output  1  high in WARMUP or CHECK
checking  output  1  high only in CHECK
fail  output  1  sticky: at least one mismatch since last start
err_cnt  output  ERR_W  mismatch count, saturating
overflow  output  1  sticky: a record was dropped because the FIFO was full
rec_valid  output  1  FIFO non-empty
rec_ready  input  1  consumer accepts head record
rec_cycle  output  CNT_W  cycle stamp of head record
rec_diff  output  WIDTH  y_1 ^ y_2 of head record

Behaviour:
- Reset (rst_n low, async): state IDLE. Cycle counter, err_cnt, FIFO pointers/count = 0. All outputs 0, including rec_cycle and rec_diff.
- States: IDLE, WARMUP, CHECK.
- IDLE: start=1 -> WARMUP if WARMUP>0, else directly CHECK. Same edge clears the cycle counter, err_cnt, fail, overflow and the FIFO.
- WARMUP: cycle counter increments every cycle. No comparisons. Transition to CHECK on the edge where the counter reaches WARMUP-1, so CHECK starts WARMUP cycles after start.
- CHECK: cycle counter increments every cycle and wraps modulo 2^CNT_W. Mismatch = (y_1 != y_2) sampled at the clock edge. No exit except start or reset.
- start while in WARMUP or CHECK: restart as from IDLE. Same clears apply and pending FIFO records are discarded. A mismatch sampled on that same edge is ignored.
- On mismatch in CHECK, at the sampling edge:
  - fail <= 1.
  - err_cnt <= err_cnt+1, holding at all-ones.
  - Push record {cycle counter value at that edge, y_1^y_2}.
- Cycle stamp: 0 on the first cycle after start. rec_cycle therefore equals cycles elapsed since start.
- Latency: fail, err_cnt and rec_valid update one clock after the mismatching sample (registered outputs). rec_valid is high the cycle after a push into an empty FIFO.
- FIFO: first-word fall-through. rec_cycle/rec_diff show the head whenever rec_valid=1 and hold their last values when empty. Pop on rec_valid & rec_ready.
- Full FIFO:
  - Push with no pop in the same cycle: record dropped, overflow <= 1. err_cnt and fail still update.
  - Push with pop in the same cycle: both take effect, count unchanged, no overflow.
- Empty FIFO with simultaneous push: new record becomes head next cycle. rec_ready while rec_valid=0 has no effect.
- rec_ready needs no particular timing; records persist across IDLE (after reset, records remain only until the next start).

Optional Feature:
EQV_STOP_ON_ERR_EN:
- Defined: the first mismatch in CHECK records normally, then the FSM returns to IDLE on that edge. busy/checking drop the next cycle; fail, err_cnt=1 and the FIFO record are retained until the next start.
- Undefined: CHECK continues indefinitely, recording every mismatch.

Test Plan:
- Reset, start, WARMUP=4, y_1==y_2 for 100 cycles -> checking high from cycle 4, fail=0, err_cnt=0, rec_valid never 1.
- y_2 = y_1^91'h1 on cycle 2 (in warm-up) and again on cycle 10 -> exactly one record, rec_cycle=10, rec_diff=91'h1, err_cnt=1, fail=1.
- rec_ready=0, mismatches on cycles 5..10 -> 4 records stamped 5..8, overflow=1, err_cnt=6. Then drain -> 4 pops in order 5,6,7,8, rec_valid=0.
- FIFO full, rec_ready=1 and a mismatch on the same cycle -> pop and push both occur, overflow stays 0, count stays 4.
- Mismatches in CHECK, then start pulse -> FIFO empty, fail=0, err_cnt=0 next cycle. Separately, rst_n low mid-CHECK -> all outputs 0 immediately (async).
- With EQV_STOP_ON_ERR_EN defined: mismatch on cycle 7 -> busy=0 the next cycle, err_cnt=1, single record rec_cycle=7. Later mismatches are ignored.
